// File: rtl/Counter_Binary.sv
// rtl/Counter_Binary.sv - up/down binary counter with synchronous load and clear
module Counter_Binary #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count = '0;

  // Load wins over counting; simultaneous inc and dec cancel out.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + ONE;
    end else if (i_dec && !i_inc) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pulse_multiplier.sv
// rtl/pulse_multiplier.sv - stretches each input pulse into a burst of multiplier output cycles
module pulse_multiplier #(
  parameter int WORD_WIDTH    = 8,
  parameter int PENDING_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [WORD_WIDTH-1:0]    multiplier,
  input  logic                     pulses_in,
  output logic                     pulse_out,
  output logic [PENDING_WIDTH-1:0] pending_count,
  output logic                     busy,
  output logic                     overflow
);

  localparam logic [WORD_WIDTH-1:0]    W_ZERO = '0;
  localparam logic [WORD_WIDTH-1:0]    W_ONE  = WORD_WIDTH'(1);
  localparam logic [PENDING_WIDTH-1:0] P_ZERO = '0;
  localparam logic [PENDING_WIDTH-1:0] P_MAX  = '1;

  logic [WORD_WIDTH-1:0]    w_remaining;
  logic [WORD_WIDTH-1:0]    w_load_value;
  logic [PENDING_WIDTH-1:0] w_pending;
  logic                     w_pending_nz;
  logic                     w_slot_free;
  logic                     w_available;
  logic                     w_start;
  logic                     w_draw;
  logic                     w_bypass;
  logic                     w_store;
  logic                     w_room;
  logic                     w_accept;
  logic                     w_drop;

  logic r_overflow = 1'b0;

  assign w_pending_nz = (w_pending != P_ZERO);
  assign w_slot_free  = (w_remaining <= W_ONE);
  assign w_available  = w_pending_nz || pulses_in;
  assign w_start      = w_slot_free && w_available;
  // Queued pulses go first so bursts stay in arrival order.
  assign w_draw       = w_start && w_pending_nz;
  assign w_bypass     = w_start && !w_pending_nz;
  assign w_store      = pulses_in && !w_bypass;
  assign w_room       = (w_pending != P_MAX) || w_draw;
  assign w_accept     = w_store && w_room;
  assign w_drop       = w_store && !w_room;
  assign w_load_value = w_available ? multiplier : W_ZERO;

  Counter_Binary #(
    .WIDTH (WORD_WIDTH)
  ) u_remaining (
    .clock        (clock),
    .clear        (clear),
    .i_load       (w_slot_free),
    .i_load_value (w_load_value),
    .i_inc        (1'b0),
    .i_dec        (1'b1),
    .o_count      (w_remaining)
  );

  Counter_Binary #(
    .WIDTH (PENDING_WIDTH)
  ) u_pending (
    .clock        (clock),
    .clear        (clear),
    .i_load       (1'b0),
    .i_load_value (P_ZERO),
    .i_inc        (w_accept),
    .i_dec        (w_draw),
    .o_count      (w_pending)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign pulse_out     = (w_remaining != W_ZERO);
  assign pending_count = w_pending;
  assign busy          = pulse_out || w_pending_nz;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_pulse_multiplier.sv
// tb/tb_pulse_multiplier.sv - self-checking bench for pulse_multiplier
module tb_pulse_multiplier;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       pulses_in = 1'b0;
  logic [7:0] multiplier = 8'd0;

  logic       po_a, busy_a, ovf_a;
  logic [3:0] pend_a;
  logic       po_b, busy_b, ovf_b;
  logic [1:0] pend_b;

  int tests = 0;
  int fails = 0;

  int m_rem[2];
  int m_pend[2];
  int m_ovf[2];
  int m_max[2];

  typedef struct {
    bit clr;
    bit pin;
    int mult;
    bit e_po;
    int e_pend;
    bit e_busy;
    bit e_ovf;
  } vec_t;

  vec_t vt[$];

  always #5 clock = ~clock;

  pulse_multiplier #(.WORD_WIDTH(8), .PENDING_WIDTH(4)) dut (
    .clock         (clock),
    .clear         (clear),
    .multiplier    (multiplier),
    .pulses_in     (pulses_in),
    .pulse_out     (po_a),
    .pending_count (pend_a),
    .busy          (busy_a),
    .overflow      (ovf_a)
  );

  pulse_multiplier #(.WORD_WIDTH(8), .PENDING_WIDTH(2)) dut_small (
    .clock         (clock),
    .clear         (clear),
    .multiplier    (multiplier),
    .pulses_in     (pulses_in),
    .pulse_out     (po_b),
    .pending_count (pend_b),
    .busy          (busy_b),
    .overflow      (ovf_b)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: owed output cycles plus a count of queued pulses.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int  rem;
      int  pend;
      bit  took_pend;
      bit  byp;
      rem = m_rem[k];
      pend = m_pend[k];
      took_pend = 0;
      byp = 0;
      if (clear) begin
        m_rem[k] = 0;
        m_pend[k] = 0;
        m_ovf[k] = 0;
      end else begin
        if (rem > 1) begin
          m_rem[k] = rem - 1;
        end else if (pend > 0 || pulses_in) begin
          m_rem[k] = int'(multiplier);
          if (pend > 0) took_pend = 1;
          else byp = 1;
        end else begin
          m_rem[k] = 0;
        end
        if (pulses_in && !byp) begin
          if (pend < m_max[k] || took_pend) pend = pend + 1;
          else m_ovf[k] = 1;
        end
        if (took_pend) pend = pend - 1;
        m_pend[k] = pend;
      end
    end
  endtask

  task automatic compare_model();
    check("model_a_pulse_out", int'(po_a), int'(m_rem[0] != 0));
    check("model_a_pending", int'(pend_a), m_pend[0]);
    check("model_a_busy", int'(busy_a), int'(m_rem[0] != 0 || m_pend[0] != 0));
    check("model_a_overflow", int'(ovf_a), m_ovf[0]);
    check("model_b_pulse_out", int'(po_b), int'(m_rem[1] != 0));
    check("model_b_pending", int'(pend_b), m_pend[1]);
    check("model_b_busy", int'(busy_b), int'(m_rem[1] != 0 || m_pend[1] != 0));
    check("model_b_overflow", int'(ovf_b), m_ovf[1]);
  endtask

  task automatic drive(input bit c, input bit p, input int m);
    clear = c;
    pulses_in = p;
    multiplier = 8'(m);
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    compare_model();
  endtask

  initial begin
    int hi_a;
    int hi_b;
    int peak_b;
    int cyc;

    m_max[0] = 15;
    m_max[1] = 3;
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0;
      m_pend[k] = 0;
      m_ovf[k] = 0;
    end

    #1;
    check("powerup_pulse_out", int'(po_a), 0);
    check("powerup_pending", int'(pend_a), 0);
    check("powerup_busy", int'(busy_a), 0);
    check("powerup_overflow", int'(ovf_a), 0);

    // Clear with a simultaneous pulse, then multiplier 2 with pulses at 0,1,2.
    vt.push_back('{1, 1, 2, 0, 0, 0, 0});
    vt.push_back('{0, 1, 2, 1, 0, 1, 0});
    vt.push_back('{0, 1, 2, 1, 1, 1, 0});
    vt.push_back('{0, 1, 2, 1, 1, 1, 0});
    vt.push_back('{0, 0, 2, 1, 1, 1, 0});
    vt.push_back('{0, 0, 2, 1, 0, 1, 0});
    vt.push_back('{0, 0, 2, 1, 0, 1, 0});
    vt.push_back('{0, 0, 2, 0, 0, 0, 0});
    vt.push_back('{0, 0, 2, 0, 0, 0, 0});
    foreach (vt[i]) begin
      drive(vt[i].clr, vt[i].pin, vt[i].mult);
      step();
      check($sformatf("vec%0d_pulse_out", i), int'(po_a), int'(vt[i].e_po));
      check($sformatf("vec%0d_pending", i), int'(pend_a), vt[i].e_pend);
      check($sformatf("vec%0d_busy", i), int'(busy_a), int'(vt[i].e_busy));
      check($sformatf("vec%0d_overflow", i), int'(ovf_a), int'(vt[i].e_ovf));
    end

    // multiplier 3, single pulse at cycle 10
    for (int c = 0; c < 16; c++) begin
      drive(0, c == 10, 3);
      step();
      check("m3_pulse_out", int'(po_a), int'(c + 1 >= 11 && c + 1 <= 13));
      if (c + 1 == 14) check("m3_busy_low", int'(busy_a), 0);
    end

    // multiplier 0 swallows pulses
    drive(1, 0, 0);
    step();
    for (int c = 0; c < 8; c++) begin
      drive(0, c < 4, 0);
      step();
      check("m0_pulse_out", int'(po_a), 0);
    end
    check("m0_pending", int'(pend_a), 0);
    check("m0_busy", int'(busy_a), 0);

    // multiplier changed mid-burst takes effect at the next start
    for (int c = 0; c < 10; c++) begin
      drive(0, c == 0 || c == 3, (c < 2) ? 5 : 1);
      step();
      check("mchg_pulse_out", int'(po_a), int'(c + 1 >= 1 && c + 1 <= 6));
    end

    // saturation of the 2-bit pending counter
    drive(1, 0, 10);
    step();
    hi_b = 0;
    peak_b = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 10);
      step();
      if (po_b) hi_b++;
      if (int'(pend_b) > peak_b) peak_b = int'(pend_b);
    end
    check("sat_peak_pending", peak_b, 3);
    check("sat_overflow", int'(ovf_b), 1);
    check("sat_no_overflow_wide", int'(ovf_a), 0);
    drive(0, 0, 10);
    cyc = 0;
    while ((busy_a || busy_b) && cyc < 200) begin
      step();
      if (po_b) hi_b++;
      cyc++;
    end
    check("sat_idle_timeout", int'(cyc < 200), 1);
    check("sat_output_cycles", hi_b, 40);

    // clear aborts a burst of 8 with two pulses pending
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 8);
      step();
    end
    check("clr_pending_before", int'(pend_a), 2);
    check("clr_small_ovf_before", int'(ovf_b), 1);
    drive(1, 1, 8);
    step();
    check("clr_pulse_out", int'(po_a), 0);
    check("clr_pending", int'(pend_a), 0);
    check("clr_overflow", int'(ovf_b), 0);
    check("clr_busy", int'(busy_a), 0);
    hi_a = 0;
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, 8);
      step();
      if (po_a || po_b) hi_a++;
    end
    check("clr_no_later_output", hi_a, 0);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      int m;
      m = int'(multiplier);
      if ($urandom_range(0, 15) == 0) m = $urandom_range(0, 5);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 45, m);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_multiplier.md
PULSE_MULTIPLIER -- requirements
Module: pulse_multiplier

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, width of `multiplier` and the burst counter.
REQ-002 SHALL have parameter PENDING_WIDTH, default 4, width of the pending-input-pulse counter.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port multiplier  input  WORD_WIDTH  output pulses per input pulse; sampled at burst start.
REQ-006 SHALL have port pulses_in  input  1  each high cycle is one input pulse.
REQ-007 SHALL have port pulse_out  output  1  each high cycle is one output pulse.
REQ-008 SHALL have port pending_count  output  PENDING_WIDTH  input pulses accepted but not yet started.
REQ-009 SHALL have port busy  output  1  high when remaining != 0 or pending_count != 0.
REQ-010 SHALL have port overflow  output  1  sticky: an input pulse was dropped.

Function
REQ-011 SHALL hold internal register remaining (WORD_WIDTH), which counts the output cycles still owed, including the current cycle.
REQ-012 SHALL drive pulse_out = (remaining != 0), decoded from registered state only, with no combinational path from any input.
REQ-013 SHALL define slot_free = (remaining <= 1) and available = (pending_count != 0) || pulses_in.
REQ-014 SHALL, when remaining > 1, decrement remaining by 1 per cycle, regardless of pulses_in.
REQ-015 SHALL, when slot_free and available, load remaining with multiplier and consume one pulse (start).
REQ-016 SHALL, when slot_free and not available, load remaining with 0.
REQ-017 SHALL take the consumed pulse from pending_count when it is nonzero; otherwise it SHALL take the current pulses_in (bypass).
REQ-018 SHALL produce exactly one cycle of latency: pulses_in high at cycle t while idle gives pulse_out high for cycles t+1 .. t+multiplier.
REQ-019 SHALL make consecutive bursts contiguous: no low gap between the last cycle of one burst and the first cycle of the next.
REQ-020 SHALL, for multiplier == 0, consume the pulse and produce no output cycles; the next available pulse starts on the following cycle.
REQ-021 SHALL update pending_count by +1 if pulses_in was accepted and not bypassed, and -1 if start drew from pending; a simultaneous accept and draw leaves it unchanged.
REQ-022 SHALL drop pulses_in when pending_count equals its maximum and no draw from pending occurs that cycle, setting overflow; pending_count SHALL saturate and never wrap.
REQ-023 SHALL ignore changes to multiplier during a burst; the new value SHALL apply only at the next start.
REQ-024 SHALL have two states, IDLE (remaining == 0) and BURST (remaining != 0), encoded by remaining itself with no separate state register.

Reset
REQ-025 SHALL, on clear high at a rising edge, set remaining = 0, pending_count = 0 and overflow = 0; pulse_out and busy SHALL be 0 the following cycle.
REQ-026 SHALL give clear priority over all other activity: a burst in progress is aborted, and pulses_in in that same cycle is discarded.
REQ-027 SHALL power up with every register at its reset value, so that no clear is needed before first use.

Structure
REQ-028 SHALL use no shared package; zero/one/max constants SHALL be module-local localparams derived from WORD_WIDTH and PENDING_WIDTH.
REQ-029 SHALL build remaining and pending_count each from an instance of Counter_Binary, the existing up/down counter with load; there SHALL be no other sub-modules.

Verification
REQ-030 SHALL cover: multiplier = 3, one pulse at cycle 10 -> pulse_out high on cycles 11-13, then low; busy low at cycle 14.
REQ-031 SHALL cover: multiplier = 2, pulses at cycles 0, 1, 2 -> pulse_out high on cycles 1-6 continuously; pending_count peaks at 1.
REQ-032 SHALL cover: PENDING_WIDTH = 2, multiplier = 10, pulses_in held high for 6 cycles -> pending_count saturates at 3, overflow = 1, 40 output cycles total.
REQ-033 SHALL cover: multiplier = 0, 4 pulses -> pulse_out never high; pending_count returns to 0 and busy drops.
REQ-034 SHALL cover: multiplier = 5, pulse at cycle 0, multiplier changed to 1 at cycle 2, second pulse at cycle 3 -> high on cycles 1-6 (5 + 1).
REQ-035 SHALL cover: clear at cycle 3 of a burst of 8 with 2 pulses pending -> pulse_out low from cycle 4, pending_count 0, overflow 0, no later output.
